// File: rtl/load_store_unit.sv
// Data-memory access stage: one load/store at a time, variable-latency memory
// handshake, load alignment/extension and a single-cycle register write.
module load_store_unit #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ls_valid,
  output logic                     ls_ready,
  input  logic                     ls_is_load,
  input  logic [2:0]               ls_funct3,
  input  logic [DATA_WIDTH-1:0]    ls_addr,
  input  logic [DATA_WIDTH-1:0]    ls_wdata,
  input  logic [ADDRESS_WIDTH-1:0] ls_rd,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [DATA_WIDTH-1:0]    mem_addr,
  output logic [3:0]               mem_be,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  input  logic                     mem_gnt,
  input  logic                     mem_rvalid,
  input  logic [DATA_WIDTH-1:0]    mem_rdata,
  output logic                     RegWrite,
  output logic [ADDRESS_WIDTH-1:0] rg_wrt_dest,
  output logic [DATA_WIDTH-1:0]    rg_wrt_data,
  output logic                     ls_err
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_WB} state_t;

  state_t                   state_q;
  logic                     ready_q, mem_req_q, mem_we_q, reg_write_q, err_q;
  logic [DATA_WIDTH-1:0]    mem_addr_q, mem_wdata_q, rg_wrt_data_q;
  logic [3:0]               mem_be_q;
  logic [ADDRESS_WIDTH-1:0] rd_q, rg_wrt_dest_q;
  logic [2:0]               funct3_q;
  logic [1:0]               addr_lo_q;
  logic                     is_load_q;

  logic                     illegal_d;
  logic [3:0]               be_d;
  logic [DATA_WIDTH-1:0]    wdata_d, ld_data_d;

  function automatic logic f_illegal(input logic ld, input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      3'b000:  f_illegal = 1'b0;
      3'b001:  f_illegal = a[0];
      3'b010:  f_illegal = (a != 2'b00);
      3'b100:  f_illegal = !ld;
      3'b101:  f_illegal = !ld || a[0];
      default: f_illegal = 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] f_byte_en(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   f_byte_en = 4'b0001 << a;
      2'b01:   f_byte_en = 4'b0011 << a;
      default: f_byte_en = 4'b1111;
    endcase
  endfunction

  function automatic logic [DATA_WIDTH-1:0] f_store_lanes(input logic [2:0] f3,
                                                         input logic [DATA_WIDTH-1:0] wd);
    case (f3[1:0])
      2'b00:   f_store_lanes = {4{wd[7:0]}};
      2'b01:   f_store_lanes = {2{wd[15:0]}};
      default: f_store_lanes = wd;
    endcase
  endfunction

  function automatic logic [DATA_WIDTH-1:0] f_load_extend(input logic [2:0] f3,
                                                         input logic [DATA_WIDTH-1:0] s);
    case (f3)
      3'b000:  f_load_extend = {{(DATA_WIDTH-8){s[7]}}, s[7:0]};
      3'b001:  f_load_extend = {{(DATA_WIDTH-16){s[15]}}, s[15:0]};
      3'b100:  f_load_extend = {{(DATA_WIDTH-8){1'b0}}, s[7:0]};
      3'b101:  f_load_extend = {{(DATA_WIDTH-16){1'b0}}, s[15:0]};
      default: f_load_extend = s;
    endcase
  endfunction

  // Request decode from live inputs and load-lane selection from the latched offset.
  always_comb begin
    illegal_d = f_illegal(ls_is_load, ls_funct3, ls_addr[1:0]);
    be_d      = f_byte_en(ls_funct3, ls_addr[1:0]);
    wdata_d   = f_store_lanes(ls_funct3, ls_wdata);
    ld_data_d = f_load_extend(funct3_q, mem_rdata >> {addr_lo_q, 3'b000});
  end

  // Transaction FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      ready_q       <= 1'b1;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_be_q      <= 4'b0000;
      mem_wdata_q   <= '0;
      reg_write_q   <= 1'b0;
      rg_wrt_dest_q <= '0;
      rg_wrt_data_q <= '0;
      err_q         <= 1'b0;
      rd_q          <= '0;
      funct3_q      <= 3'b000;
      addr_lo_q     <= 2'b00;
      is_load_q     <= 1'b0;
    end else begin
      reg_write_q <= 1'b0;
      err_q       <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (ls_valid) begin
            if (illegal_d) begin
              err_q <= 1'b1;
            end else begin
              state_q     <= S_REQ;
              ready_q     <= 1'b0;
              mem_req_q   <= 1'b1;
              mem_we_q    <= !ls_is_load;
              mem_addr_q  <= {ls_addr[DATA_WIDTH-1:2], 2'b00};
              mem_be_q    <= be_d;
              mem_wdata_q <= wdata_d;
              rd_q        <= ls_rd;
              funct3_q    <= ls_funct3;
              addr_lo_q   <= ls_addr[1:0];
              is_load_q   <= ls_is_load;
            end
          end
        end
        S_REQ: begin
          if (mem_gnt) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            if (is_load_q) begin
              state_q <= S_WAIT;
            end else begin
              state_q <= S_IDLE;
              ready_q <= 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (mem_rvalid) begin
            state_q       <= S_WB;
            rg_wrt_data_q <= ld_data_d;
            rg_wrt_dest_q <= rd_q;
            // x0 is hard-wired zero, so the write strobe is suppressed.
            reg_write_q   <= (rd_q != '0);
          end
        end
        S_WB: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign ls_ready    = ready_q;
  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_be      = mem_be_q;
  assign mem_wdata   = mem_wdata_q;
  assign RegWrite    = reg_write_q;
  assign rg_wrt_dest = rg_wrt_dest_q;
  assign rg_wrt_data = rg_wrt_data_q;
  assign ls_err      = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench: stimulus pushes expected memory requests, register writes
// and error pulses; a negedge monitor pops and compares what the DUT presents.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        ls_valid, ls_is_load;
  logic [2:0]  ls_funct3;
  logic [31:0] ls_addr, ls_wdata;
  logic [4:0]  ls_rd;
  logic        ls_ready, mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        RegWrite, ls_err;
  logic [4:0]  rg_wrt_dest;
  logic [31:0] rg_wrt_data;

  int checks   = 0;
  int failures = 0;
  int err_exp  = 0;
  logic [68:0] mem_q[$];
  logic [36:0] wr_q[$];

  load_store_unit #(.DATA_WIDTH(32), .ADDRESS_WIDTH(5)) dut (
    .clk(clk), .rst(rst), .ls_valid(ls_valid), .ls_ready(ls_ready),
    .ls_is_load(ls_is_load), .ls_funct3(ls_funct3), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_rd(ls_rd), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .RegWrite(RegWrite), .rg_wrt_dest(rg_wrt_dest), .rg_wrt_data(rg_wrt_data),
    .ls_err(ls_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every presented memory request, register write and error pulse.
  always @(negedge clk) begin
    if (rst) begin
      if (mem_req) begin
        if (mem_q.size() == 0) begin
          chk("unexpected_mem_req", 32'd1, 32'd0);
        end else begin
          chk("mem_we", {31'd0, mem_we}, {31'd0, mem_q[0][68]});
          chk("mem_addr", mem_addr, mem_q[0][67:36]);
          chk("mem_be", {28'd0, mem_be}, {28'd0, mem_q[0][35:32]});
          if (mem_q[0][68]) chk("mem_wdata", mem_wdata, mem_q[0][31:0]);
          if (mem_gnt) void'(mem_q.pop_front());
        end
      end
      if (RegWrite) begin
        if (wr_q.size() == 0) begin
          chk("unexpected_regwrite", 32'd1, 32'd0);
        end else begin
          chk("rg_wrt_dest", {27'd0, rg_wrt_dest}, {27'd0, wr_q[0][36:32]});
          chk("rg_wrt_data", rg_wrt_data, wr_q[0][31:0]);
          void'(wr_q.pop_front());
        end
      end
      if (ls_err) begin
        chk("unexpected_ls_err", {31'd0, (err_exp == 0)}, 32'd0);
        if (err_exp > 0) err_exp--;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic xact(input logic ld, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [4:0] rd, input int gdly,
                      input int rdly, input logic [31:0] rdata, input logic [3:0] ebe,
                      input logic [31:0] ewd, input logic [31:0] edata, input logic ill);
    chk("ready_before", {31'd0, ls_ready}, 32'd1);
    ls_valid = 1'b1; ls_is_load = ld; ls_funct3 = f3; ls_addr = addr;
    ls_wdata = wd; ls_rd = rd;
    if (ill) err_exp++;
    else mem_q.push_back({~ld, addr & 32'hFFFF_FFFC, ebe, ewd});
    if (!ill && ld && rd != 5'd0) wr_q.push_back({rd, edata});
    tick();
    ls_valid = 1'b0;
    if (ill) begin
      chk("ill_err", {31'd0, ls_err}, 32'd1);
      chk("ill_ready", {31'd0, ls_ready}, 32'd1);
      chk("ill_noreq", {31'd0, mem_req}, 32'd0);
      tick();
      chk("ill_err_cleared", {31'd0, ls_err}, 32'd0);
      chk("ill_noreq2", {31'd0, mem_req}, 32'd0);
    end else begin
      chk("req_asserted", {31'd0, mem_req}, 32'd1);
      repeat (gdly) tick();
      mem_gnt = 1'b1;
      tick();
      mem_gnt = 1'b0;
      chk("req_dropped", {31'd0, mem_req}, 32'd0);
      if (!ld) begin
        chk("st_ready", {31'd0, ls_ready}, 32'd1);
        chk("st_noregwrite", {31'd0, RegWrite}, 32'd0);
      end else begin
        chk("wait_ready", {31'd0, ls_ready}, 32'd0);
        repeat (rdly) tick();
        mem_rvalid = 1'b1; mem_rdata = rdata;
        tick();
        mem_rvalid = 1'b0; mem_rdata = 32'h0;
        chk("wb_regwrite", {31'd0, RegWrite}, {31'd0, (rd != 5'd0)});
        chk("wb_ready", {31'd0, ls_ready}, 32'd0);
        tick();
        chk("post_wb_regwrite", {31'd0, RegWrite}, 32'd0);
        chk("post_wb_ready", {31'd0, ls_ready}, 32'd1);
      end
    end
  endtask

  initial begin
    rst = 1'b0; ls_valid = 1'b0; ls_is_load = 1'b0; ls_funct3 = 3'b000;
    ls_addr = 32'h0; ls_wdata = 32'h0; ls_rd = 5'd0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, ls_ready}, 32'd1);
    chk("rst_outs", {28'd0, mem_req, mem_we, RegWrite, ls_err}, 32'd0);
    chk("rst_mem_addr", mem_addr | mem_wdata | {28'd0, mem_be}, 32'd0);
    chk("rst_rg", rg_wrt_data | {27'd0, rg_wrt_dest}, 32'd0);
    rst = 1'b1;
    tick();

    // Directed vectors: ld, f3, addr, wdata, rd, gnt delay, rvalid delay, rdata, be, wdata lanes, load result, illegal
    xact(1'b1, 3'b000, 32'h103, 32'h0, 5'd5, 0, 0, 32'h80FF_FF7F, 4'b1000, 32'h0, 32'hFFFF_FF80, 1'b0);
    xact(1'b1, 3'b101, 32'h102, 32'h0, 5'd7, 0, 1, 32'hBEEF_1234, 4'b1100, 32'h0, 32'h0000_BEEF, 1'b0);
    xact(1'b1, 3'b010, 32'h200, 32'h0, 5'd31, 3, 2, 32'hDEAD_BEEF, 4'b1111, 32'h0, 32'hDEAD_BEEF, 1'b0);
    xact(1'b0, 3'b000, 32'h101, 32'h1234_56AB, 5'd0, 0, 0, 32'h0, 4'b0010, 32'hABAB_ABAB, 32'h0, 1'b0);
    xact(1'b0, 3'b001, 32'h102, 32'h0000_CAFE, 5'd0, 2, 0, 32'h0, 4'b1100, 32'hCAFE_CAFE, 32'h0, 1'b0);
    xact(1'b1, 3'b001, 32'h100, 32'h0, 5'd9, 0, 0, 32'h0000_8001, 4'b0011, 32'h0, 32'hFFFF_8001, 1'b0);
    xact(1'b1, 3'b100, 32'h102, 32'h0, 5'd10, 1, 0, 32'h00F0_0000, 4'b0100, 32'h0, 32'h0000_00F0, 1'b0);
    xact(1'b0, 3'b010, 32'h300, 32'h1122_3344, 5'd0, 0, 0, 32'h0, 4'b1111, 32'h1122_3344, 32'h0, 1'b0);
    xact(1'b1, 3'b010, 32'h102, 32'h0, 5'd4, 0, 0, 32'h0, 4'b0000, 32'h0, 32'h0, 1'b1);
    xact(1'b0, 3'b001, 32'h001, 32'h0, 5'd0, 0, 0, 32'h0, 4'b0000, 32'h0, 32'h0, 1'b1);
    xact(1'b1, 3'b011, 32'h000, 32'h0, 5'd4, 0, 0, 32'h0, 4'b0000, 32'h0, 32'h0, 1'b1);
    xact(1'b0, 3'b100, 32'h000, 32'h0, 5'd0, 0, 0, 32'h0, 4'b0000, 32'h0, 32'h0, 1'b1);
    xact(1'b1, 3'b010, 32'h010, 32'h0, 5'd0, 0, 0, 32'h0000_0005, 4'b1111, 32'h0, 32'h5, 1'b0);

    // Spurious read data while idle must be ignored.
    mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    repeat (2) tick();
    mem_rvalid = 1'b0;
    chk("spurious_ready", {31'd0, ls_ready}, 32'd1);
    chk("spurious_noregwrite", {31'd0, RegWrite}, 32'd0);

    // Reset while waiting for load data abandons the transaction.
    ls_valid = 1'b1; ls_is_load = 1'b1; ls_funct3 = 3'b010; ls_addr = 32'h40; ls_rd = 5'd3;
    mem_q.push_back({1'b0, 32'h40, 4'b1111, 32'h0});
    tick();
    ls_valid = 1'b0; mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    rst = 1'b0;
    #2;
    chk("midrst_ready", {31'd0, ls_ready}, 32'd1);
    chk("midrst_outs", {28'd0, mem_req, mem_we, RegWrite, ls_err}, 32'd0);
    chk("midrst_vals", mem_addr | mem_wdata | rg_wrt_data | {28'd0, mem_be}, 32'd0);
    chk("midrst_dest", {27'd0, rg_wrt_dest}, 32'd0);
    tick();
    rst = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    repeat (3) tick();
    mem_rvalid = 1'b0;
    chk("midrst_noregwrite", {31'd0, RegWrite}, 32'd0);
    chk("midrst_ready_after", {31'd0, ls_ready}, 32'd1);
    tick();

    chk("mem_q_drained", mem_q.size(), 32'd0);
    chk("wr_q_drained", wr_q.size(), 32'd0);
    chk("err_all_seen", err_exp, 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
